// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encoding, response codes and the read
// responder's state encoding. Used by the read responder and the burst
// address calculator (which the write path also instantiates).
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_SEND = 2'b11
  } rd_state_e;

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for AXI FIXED / INCR / WRAP bursts.
// Reserved burst type 11 falls through to INCR. All adds wrap modulo
// 2^ADDR_WIDTH; the 4 KB boundary is deliberately not considered.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  burst_e                burst_i,
  input  logic [2:0]            size_i,
  input  logic [7:0]            len_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] inc;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  assign inc       = ONE << size_i;
  // Wrap window is the whole burst: (len+1) beats of 2^size bytes.
  assign wrap_mask = ((ADDR_WIDTH'(len_i) + ONE) << size_i) - ONE;

  // Select the next address by burst type.
  always_comb begin
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | ((addr_i + inc) & wrap_mask);
      // Aligning before the add makes only the first INCR beat unaligned.
      default:     next_addr_o = (addr_i & ~(inc - ONE)) + inc;
    endcase
  end

endmodule

// File: rtl/axi_read_responder.sv
// AXI read-data-channel responder: pops one AR request, issues one cache
// lookup per beat, and returns each beat on R with rid/rresp/rlast.
// Optional feature macro RD_BURST_CHECK_EN: when defined, illegal AR
// requests bypass the cache and return len+1 SLVERR beats with zero data.
module axi_read_responder
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ar_valid,
  output logic                  ar_ready,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  input  logic [ID_WIDTH-1:0]   ar_id,
  input  logic [1:0]            ar_burst,
  input  logic [2:0]            ar_size,
  input  logic [7:0]            ar_len,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] rd_rsp_data,
  input  logic                  rd_rsp_err,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [1:0]            rresp,
  output logic                  rlast
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  burst_e                burst_q, burst_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  illegal_q, illegal_d;

  logic                  ar_hs;
  logic                  last_beat;
  logic                  ar_illegal;
  logic [ADDR_WIDTH-1:0] next_addr;

`ifdef RD_BURST_CHECK_EN
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  // Flag AR requests the cache must never see.
  always_comb begin
    ar_illegal = (ar_burst == BURST_RSVD) || (ar_size > MAX_SIZE);
    if (ar_burst == BURST_WRAP) begin
      if (!(ar_len == 8'd1 || ar_len == 8'd3 || ar_len == 8'd7 || ar_len == 8'd15))
        ar_illegal = 1'b1;
      if ((ar_addr & ((ONE << ar_size) - ONE)) != '0)
        ar_illegal = 1'b1;
    end
  end
`else
  assign ar_illegal = 1'b0;
`endif

  // ar_ready is gated by rst_n so it reads 0 for the whole reset pulse.
  assign ar_ready     = rst_n && (state_q == ST_IDLE);
  assign ar_hs        = ar_valid && ar_ready;
  assign last_beat    = (cnt_q == len_q);
  assign rd_req_valid = (state_q == ST_REQ);
  assign rd_req_addr  = (state_q == ST_REQ) ? addr_q : '0;
  assign rvalid       = (state_q == ST_SEND);
  assign rlast        = (state_q == ST_SEND) && last_beat;
  assign rdata        = rdata_q;
  assign rresp        = rresp_q;
  assign rid          = id_q;

  axi_burst_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_burst_addr (
    .addr_i      (addr_q),
    .burst_i     (burst_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .next_addr_o (next_addr)
  );

  // Burst FSM: IDLE -> REQ -> WAIT -> SEND, looping per beat.
  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    burst_d   = burst_q;
    size_d    = size_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          addr_d    = ar_addr;
          id_d      = ar_id;
          burst_d   = burst_e'(ar_burst);
          size_d    = ar_size;
          len_d     = ar_len;
          cnt_d     = '0;
          illegal_d = ar_illegal;
          if (ar_illegal) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
            state_d = ST_SEND;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (rd_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rd_rsp_valid) begin
          rdata_d = rd_rsp_data;
          rresp_d = rd_rsp_err ? RESP_SLVERR : RESP_OKAY;
          state_d = ST_SEND;
        end
      end
      default: begin // ST_SEND
        if (rready) begin
          if (last_beat) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
            // Illegal bursts stay in SEND; rdata/rresp already hold 0/SLVERR.
            if (!illegal_q) begin
              addr_d  = next_addr;
              state_d = ST_REQ;
            end
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      burst_q   <= BURST_FIXED;
      size_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      burst_q   <= burst_d;
      size_q    <= size_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: a queue-based model predicts
// every lookup address and every R beat; directed bursts pin literal values,
// then randomized bursts run with random back-pressure and cache latency.
module tb_axi_read_responder;
  import axi_pkg::*;

  localparam int AW = 64;
  localparam int IW = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ar_valid = 1'b0;
  logic          ar_ready;
  logic [AW-1:0] ar_addr = '0;
  logic [IW-1:0] ar_id = '0;
  logic [1:0]    ar_burst = '0;
  logic [2:0]    ar_size = '0;
  logic [7:0]    ar_len = '0;
  logic          rd_req_valid;
  logic          rd_req_ready = 1'b0;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid = 1'b0;
  logic [DW-1:0] rd_rsp_data = '0;
  logic          rd_rsp_err = 1'b0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [IW-1:0] rid;
  logic [1:0]    rresp;
  logic          rlast;

  always #5 clk = ~clk;

  axi_read_responder #(.ADDR_WIDTH(AW), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_burst(ar_burst), .ar_size(ar_size), .ar_len(ar_len),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data), .rd_rsp_err(rd_rsp_err),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
    logic [IW-1:0] id;
  } beat_t;

  // Model state
  logic [AW-1:0] exp_addr_q[$];
  beat_t         exp_r_q[$];
  bit            awaiting = 0;
  int            beat_idx = 0;
  logic [7:0]    cur_len = '0;
  logic [IW-1:0] cur_id = '0;

  // Observation logs for directed literal checks
  logic [AW-1:0] obs_addr[$];
  logic [1:0]    obs_resp[$];
  logic          obs_last[$];
  logic [IW-1:0] obs_id[$];
  int            req_count = 0;

  // Cache / master behaviour knobs
  bit  req_hs = 0;
  int  pend = -1;
  int  ready_pct = 100, rready_pct = 100, err_pct = 0, dly_max = 0;
  bit  spur_en = 0;
  bit  err_plan[$];

  // Address of beat i computed directly from the burst rules.
  function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [1:0] b,
                                            input logic [2:0] s, input logic [7:0] l, input int i);
    logic [63:0] inc, mask;
    inc  = 64'd1 << s;
    mask = (64'(l) + 64'd1) * inc - 64'd1;
    case (b)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + 64'(i) * inc) & mask);
      default: return (i == 0) ? a : (a / inc) * inc + 64'(i) * inc;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [63:0] a, input logic [1:0] b,
                                    input logic [2:0] s, input logic [7:0] l);
`ifdef RD_BURST_CHECK_EN
    if (b == 2'b11) return 1;
    if (s > 3'd3) return 1;
    if (b == 2'b10 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15)) return 1;
    if (b == 2'b10 && (a % (64'd1 << s)) != 0) return 1;
    return 0;
`else
    return (a == 64'd1) && (b == 2'b11) && (s == 3'd7) && (l == 8'd255) && 1'b0;
`endif
  endfunction

  // Model + compare: everything sampled mid-cycle predicts the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs_zero",
            {63'd0, ar_ready | rd_req_valid | rvalid | rlast | (|rresp) | (|rid) | (|rdata) | (|rd_req_addr)},
            64'd0);
      exp_addr_q.delete();
      exp_r_q.delete();
      awaiting = 0;
    end else begin
      if (ar_valid && ar_ready) begin
        cur_len  = ar_len;
        cur_id   = ar_id;
        beat_idx = 0;
        for (int i = 0; i <= int'(ar_len); i++) begin
          if (is_illegal(ar_addr, ar_burst, ar_size, ar_len)) begin
            beat_t bt;
            bt.data = '0; bt.resp = 2'b10; bt.last = (i == int'(ar_len)); bt.id = ar_id;
            exp_r_q.push_back(bt);
          end else begin
            exp_addr_q.push_back(beat_addr(ar_addr, ar_burst, ar_size, ar_len, i));
          end
        end
      end
      if (rd_rsp_valid && awaiting) begin
        beat_t bt;
        bt.data = rd_rsp_data;
        bt.resp = rd_rsp_err ? 2'b10 : 2'b00;
        bt.last = (beat_idx == int'(cur_len));
        bt.id   = cur_id;
        exp_r_q.push_back(bt);
        beat_idx++;
        awaiting = 0;
      end
      if (rd_req_valid) begin
        check("req_only_when_nothing_pending", {63'd0, (exp_r_q.size() != 0) || awaiting}, 64'd0);
        if (exp_addr_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
        else begin
          check("rd_req_addr", rd_req_addr, exp_addr_q[0]);
          if (rd_req_ready) begin
            void'(exp_addr_q.pop_front());
            obs_addr.push_back(rd_req_addr);
            req_count++;
            awaiting = 1;
            req_hs   = 1;
          end
        end
      end
      if (rvalid) begin
        if (exp_r_q.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
        else begin
          check("rdata", rdata, exp_r_q[0].data);
          check("rresp", {62'd0, rresp}, {62'd0, exp_r_q[0].resp});
          check("rlast", {63'd0, rlast}, {63'd0, exp_r_q[0].last});
          check("rid",   {60'd0, rid},   {60'd0, exp_r_q[0].id});
          if (rready) begin
            obs_resp.push_back(rresp);
            obs_last.push_back(rlast);
            obs_id.push_back(rid);
            void'(exp_r_q.pop_front());
          end
        end
      end
    end
  end

  // Cache and R-master behaviour, driven just after each rising edge.
  always @(posedge clk) begin
    #1;
    rd_rsp_valid = 1'b0;
    if (req_hs) begin
      req_hs = 0;
      pend   = int'($urandom_range(0, dly_max));
    end else if (pend > 0) begin
      pend--;
    end
    if (pend == 0) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = {$urandom, $urandom};
      if (err_plan.size() != 0) rd_rsp_err = err_plan.pop_front();
      else rd_rsp_err = ($urandom_range(0, 99) < err_pct);
      pend = -1;
    end else if (spur_en && pend < 0 && !awaiting && $urandom_range(0, 9) == 0) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = {$urandom, $urandom};
      rd_rsp_err   = $urandom_range(0, 1) == 1;
    end
    rd_req_ready = ($urandom_range(0, 99) < ready_pct);
    rready       = ($urandom_range(0, 99) < rready_pct);
  end

  task automatic send_ar(input logic [63:0] a, input logic [3:0] id, input logic [1:0] b,
                         input logic [2:0] s, input logic [7:0] l);
    bit done = 0;
    @(posedge clk); #1;
    ar_valid = 1'b1; ar_addr = a; ar_id = id; ar_burst = b; ar_size = s; ar_len = l;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (ar_ready) done = 1;
    end
    if (!done) check("ar_accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk); #1;
      if (exp_addr_q.size() == 0 && exp_r_q.size() == 0 && !awaiting && ar_ready) done = 1;
    end
    if (!done) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_resp.delete(); obs_last.delete(); obs_id.delete();
    req_count = 0;
  endtask

  task automatic check_addrs(input string name, input logic [63:0] e0, input logic [63:0] e1,
                             input logic [63:0] e2, input logic [63:0] e3, input int n);
    logic [63:0] e[4];
    e = '{e0, e1, e2, e3};
    check({name, "_count"}, 64'(obs_addr.size()), 64'(n));
    for (int i = 0; i < n && i < obs_addr.size(); i++) check({name, "_addr"}, obs_addr[i], e[i]);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalled_req;
    bit seen;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ar_ready_after_reset", {63'd0, ar_ready}, 64'd1);

    // Model pinned by hand-computed WRAP/INCR addresses.
    check("model_wrap_beat1", beat_addr(64'h38, 2'b10, 3'd3, 8'd3, 1), 64'h20);
    check("model_incr_unaligned", beat_addr(64'h103, 2'b01, 3'd2, 8'd3, 2), 64'h108);

    // INCR 0x100, size 3, len 3, rready always high.
    clear_obs();
    send_ar(64'h100, 4'h5, 2'b01, 3'd3, 8'd3);
    wait_done("incr");
    check_addrs("incr", 64'h100, 64'h108, 64'h110, 64'h118, 4);
    check("incr_beats", 64'(obs_resp.size()), 64'd4);
    for (int i = 0; i < obs_resp.size(); i++) begin
      check("incr_resp", {62'd0, obs_resp[i]}, 64'd0);
      check("incr_last", {63'd0, obs_last[i]}, (i == 3) ? 64'd1 : 64'd0);
      check("incr_rid",  {60'd0, obs_id[i]}, 64'h5);
    end

    // WRAP 0x38, size 3, len 3.
    clear_obs();
    send_ar(64'h38, 4'h2, 2'b10, 3'd3, 8'd3);
    wait_done("wrap");
    check_addrs("wrap", 64'h38, 64'h20, 64'h28, 64'h30, 4);

    // FIXED 0x40, len 2, error on beat 1 only.
    clear_obs();
    err_plan.push_back(1'b0); err_plan.push_back(1'b1); err_plan.push_back(1'b0);
    send_ar(64'h40, 4'h9, 2'b00, 3'd3, 8'd2);
    wait_done("fixed");
    check_addrs("fixed", 64'h40, 64'h40, 64'h40, 64'h0, 3);
    check("fixed_beats", 64'(obs_resp.size()), 64'd3);
    if (obs_resp.size() == 3) begin
      check("fixed_resp0", {62'd0, obs_resp[0]}, 64'd0);
      check("fixed_resp1", {62'd0, obs_resp[1]}, 64'd2);
      check("fixed_resp2", {62'd0, obs_resp[2]}, 64'd0);
    end

    // rready held low five cycles during beat 0.
    clear_obs();
    rready_pct = 0;
    send_ar(64'h1000, 4'h3, 2'b01, 3'd3, 8'd1);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #1;
      if (rvalid) seen = 1;
    end
    check("stall_rvalid_seen", {63'd0, seen}, 64'd1);
    stalled_req = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_req_valid) stalled_req++;
    end
    check("stall_no_new_req", 64'(stalled_req), 64'd0);
    check("stall_one_lookup", 64'(req_count), 64'd1);
    rready_pct = 100;
    wait_done("stall");
    check("stall_beats", 64'(obs_resp.size()), 64'd2);

    // Reset during WAIT of a len=7 burst; late cache response must be ignored.
    dly_max = 2;
    send_ar(64'h2000, 4'h6, 2'b01, 3'd3, 8'd7);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk); #1;
      if (awaiting) seen = 1;
    end
    check("reset_test_reached_wait", {63'd0, seen}, 64'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ar_ready_after_midburst_reset", {63'd0, ar_ready}, 64'd1);
    check("rvalid_after_midburst_reset", {63'd0, rvalid}, 64'd0);
    clear_obs();
    send_ar(64'h3000, 4'hA, 2'b01, 3'd3, 8'd3);
    wait_done("post_reset");
    check_addrs("post_reset", 64'h3000, 64'h3008, 64'h3010, 64'h3018, 4);
    dly_max = 0;

    // Reserved burst type 11, len 1.
    clear_obs();
    send_ar(64'h300, 4'h4, 2'b11, 3'd3, 8'd1);
    wait_done("rsvd");
`ifdef RD_BURST_CHECK_EN
    check("rsvd_no_lookups", 64'(req_count), 64'd0);
    check("rsvd_beats", 64'(obs_resp.size()), 64'd2);
    for (int i = 0; i < obs_resp.size(); i++) check("rsvd_slverr", {62'd0, obs_resp[i]}, 64'd2);
`else
    check_addrs("rsvd_as_incr", 64'h300, 64'h308, 64'h0, 64'h0, 2);
`endif

    // Randomized bursts, back-to-back AR, random handshakes and latency.
    ready_pct = 70; rready_pct = 60; err_pct = 20; dly_max = 2; spur_en = 1;
    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      logic [1:0]  b;
      logic [2:0]  s;
      logic [7:0]  l;
      b = 2'($urandom_range(0, 2));
      s = 3'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0;
      if (b == 2'b10) begin
        case ($urandom_range(0, 3))
          0: l = 8'd1;
          1: l = 8'd3;
          2: l = 8'd7;
          default: l = 8'd15;
        endcase
        a = a & ~((64'd1 << s) - 64'd1);
      end else begin
        l = ($urandom_range(0, 24) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
      end
      send_ar(a, 4'($urandom_range(0, 15)), b, s, l);
    end
    wait_done("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
